// File: rtl/seg7_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package seg7_scan_pkg;

   localparam int MAX_DIG = 8;

   // Active-low digit enables: every digit dark.
   localparam logic [MAX_DIG-1:0] AN_ALL_OFF = '1;

   typedef enum logic {PH_BLANK, PH_ON} phase_e;

   // ceil(log2(n)), never below 1 so a 1-bit register still exists.
   function automatic int clog2w(input int n);
      for (int w = 1; w < 32; w++) begin
         if ((1 << w) >= n) return w;
      end
      return 32;
   endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running modulo-PRESCALE slot counter with terminal-count and blank-end strobes.
module seg7_prescaler
   import seg7_scan_pkg::*;
#(
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 1000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tc_o,
   output logic blank_end_o
);

   localparam int CW = clog2w(PRESCALE);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o        = (cnt_q == CW'(PRESCALE - 1));
   assign blank_end_o = (cnt_q == CW'(BLANK_CYC - 1));
   assign cnt_d       = tc_o ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg7_scan.sv
// NDIG-digit common-anode scanner: double-buffered value, inter-digit blanking,
// optional leading-zero suppression. Feeds DIN/DOT to the hex-to-segment decoder.
module seg7_scan
   import seg7_scan_pkg::*;
#(
   parameter int NDIG      = 8,
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 1000
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              LOAD,
   input  logic [4*NDIG-1:0] VALUE,
   input  logic [NDIG-1:0]   DOTS,
   input  logic              LZS,
   output logic [3:0]        DIN,
   output logic              DOT,
   output logic [NDIG-1:0]   nAN,
   output logic              FRAME
);

   localparam int              IW       = clog2w(NDIG);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NDIG - 1);
   localparam logic [NDIG-1:0] AN_OFF   = AN_ALL_OFF[NDIG-1:0];

   logic tc, blank_end, frame_edge;

   phase_e                 ph_q, ph_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NDIG-1:0][3:0]   pend_val_q, pend_val_d, act_val_q, act_val_d;
   logic [NDIG-1:0]        pend_dots_q, pend_dots_d, act_dots_q, act_dots_d;
   logic                   dirty_q, dirty_d;
   logic [3:0]             din_q, din_d;
   logic                   dot_q, dot_d;
   logic [NDIG-1:0]        nan_q, nan_d;
   logic                   frame_q, frame_d;
   logic [NDIG-1:0]        supp;
   logic                   allz;

   seg7_prescaler #(
      .PRESCALE  (PRESCALE),
      .BLANK_CYC (BLANK_CYC)
   ) u_pre (
      .clk_i       (CLK),
      .rst_ni      (nRST),
      .tc_o        (tc),
      .blank_end_o (blank_end)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ph_q        <= PH_BLANK;
         idx_q       <= '0;
         pend_val_q  <= '0;
         pend_dots_q <= '0;
         act_val_q   <= '0;
         act_dots_q  <= '0;
         dirty_q     <= 1'b0;
         din_q       <= '0;
         dot_q       <= 1'b0;
         nan_q       <= AN_OFF;
         frame_q     <= 1'b0;
      end else begin
         ph_q        <= ph_d;
         idx_q       <= idx_d;
         pend_val_q  <= pend_val_d;
         pend_dots_q <= pend_dots_d;
         act_val_q   <= act_val_d;
         act_dots_q  <= act_dots_d;
         dirty_q     <= dirty_d;
         din_q       <= din_d;
         dot_q       <= dot_d;
         nan_q       <= nan_d;
         frame_q     <= frame_d;
      end
   end

   always_comb begin
      ph_d  = ph_q;
      idx_d = idx_q;
      case (ph_q)
         PH_BLANK: if (blank_end) ph_d = PH_ON;
         PH_ON: begin
            if (tc) begin
               ph_d  = PH_BLANK;
               idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
         end
         default: ph_d = PH_BLANK;
      endcase
   end

   // Frame boundary: the swap point; a LOAD landing here skips the pending buffer.
   assign frame_edge = tc && (ph_q == PH_ON) && (idx_q == LAST_IDX);

   always_comb begin
      pend_val_d  = pend_val_q;
      pend_dots_d = pend_dots_q;
      act_val_d   = act_val_q;
      act_dots_d  = act_dots_q;
      dirty_d     = dirty_q;
      frame_d     = 1'b0;
      if (frame_edge) begin
         if (LOAD) begin
            act_val_d  = VALUE;
            act_dots_d = DOTS;
            dirty_d    = 1'b0;
            frame_d    = 1'b1;
         end else if (dirty_q) begin
            act_val_d  = pend_val_q;
            act_dots_d = pend_dots_q;
            dirty_d    = 1'b0;
            frame_d    = 1'b1;
         end
      end else if (LOAD) begin
         pend_val_d  = VALUE;
         pend_dots_d = DOTS;
         dirty_d     = 1'b1;
      end
   end

   // Digit i is suppressed when it and everything above it is blank (no nibble, no dot).
   always_comb begin
      supp = '0;
      allz = 1'b1;
      for (int i = NDIG - 1; i > 0; i--) begin
         allz    = allz & (act_val_q[i] == 4'h0) & ~act_dots_q[i];
         supp[i] = LZS & allz;
      end
   end

   // DIN/DOT change only when entering BLANK, so the decoder settles before the anode lights.
   always_comb begin
      din_d = din_q;
      dot_d = dot_q;
      nan_d = AN_OFF;
      if (ph_q == PH_ON && tc) begin
         din_d = act_val_d[idx_d];
         dot_d = act_dots_d[idx_d];
      end
      if (ph_d == PH_ON && !supp[idx_d]) nan_d[idx_d] = 1'b0;
   end

   assign DIN   = din_q;
   assign DOT   = dot_q;
   assign nAN   = nan_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with NDIG=4, PRESCALE=8, BLANK_CYC=2.
module tb_seg7_scan;

   localparam int ND = 4;
   localparam int PS = 8;
   localparam int BC = 2;
   localparam int FR = ND * PS;

   logic          CLK, nRST, LOAD, LZS;
   logic [4*ND-1:0] VALUE;
   logic [ND-1:0] DOTS;
   logic [3:0]    DIN;
   logic          DOT;
   logic [ND-1:0] nAN;
   logic          FRAME;

   seg7_scan #(.NDIG(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
      .CLK   (CLK),
      .nRST  (nRST),
      .LOAD  (LOAD),
      .VALUE (VALUE),
      .DOTS  (DOTS),
      .LZS   (LZS),
      .DIN   (DIN),
      .DOT   (DOT),
      .nAN   (nAN),
      .FRAME (FRAME)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Scoreboard: frames expected to appear at the next digit-0 boundary.
   logic [4*ND+ND-1:0] sbq[$];
   logic [4*ND-1:0]    pend_v, disp_v;
   logic [ND-1:0]      pend_d, disp_d;
   bit                 pend_ok, lzs_edge, prev_lit;
   logic [3:0]         prev_din;
   logic               prev_dot;

   typedef struct {
      int         cyc;
      logic [3:0] nan;
      logic [3:0] din;
      logic       dot;
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit supp(input int s);
      if (s == 0 || !lzs_edge) return 1'b0;
      for (int i = s; i < ND; i++)
         if (disp_v[i*4 +: 4] != 4'h0 || disp_d[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      sbq.delete();
      pend_ok  = 1'b0;
      disp_v   = '0;
      disp_d   = '0;
      prev_lit = 1'b0;
      lzs_edge = LZS;
   endtask

   task automatic monitor();
      int         pos, slot;
      bit         exp_fr;
      logic [3:0] en;
      pos  = cyc % PS;
      slot = (cyc / PS) % ND;
      exp_fr = 1'b0;
      if (cyc % FR == 0) begin
         exp_fr = (sbq.size() > 0);
         if (exp_fr) {disp_d, disp_v} = sbq.pop_front();
      end
      chk("frame", 32'(FRAME), 32'(exp_fr));
      en = 4'hF;
      if (pos >= BC && !supp(slot)) en[slot] = 1'b0;
      chk("nan", 32'(nAN), 32'(en));
      chk("din", 32'(DIN), 32'(disp_v[slot*4 +: 4]));
      chk("dot", 32'(DOT), 32'(disp_d[slot]));
      chk("onehot", 32'($countones(~nAN) <= 1), 1);
      if (pos < BC) chk("blank", 32'(nAN), 32'hF);
      if (prev_lit && nAN != 4'hF) chk("din_stable", 32'({DIN, DOT}), 32'({prev_din, prev_dot}));
      prev_lit = (nAN != 4'hF);
      prev_din = DIN;
      prev_dot = DOT;
   endtask

   task automatic tick();
      if (LOAD) begin
         pend_v  = VALUE;
         pend_d  = DOTS;
         pend_ok = 1'b1;
      end
      if (cyc % FR == FR - 1 && pend_ok) begin
         sbq.push_back({pend_d, pend_v});
         pend_ok = 1'b0;
      end
      lzs_edge = LZS;
      @(posedge CLK);
      #1;
      cyc++;
      LOAD = 1'b0;
      monitor();
   endtask

   task automatic run_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic load(input logic [4*ND-1:0] v, input logic [ND-1:0] d);
      VALUE = v;
      DOTS  = d;
      LOAD  = 1'b1;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ed[4];
      logic       eo[4];
      int         nfr;

      vt[0]  = '{0,  4'hF, 4'h0, 1'b0};
      vt[1]  = '{1,  4'hF, 4'h0, 1'b0};
      vt[2]  = '{2,  4'hE, 4'h0, 1'b0};
      vt[3]  = '{7,  4'hE, 4'h0, 1'b0};
      vt[4]  = '{8,  4'hF, 4'h0, 1'b0};
      vt[5]  = '{9,  4'hF, 4'h0, 1'b0};
      vt[6]  = '{10, 4'hD, 4'h0, 1'b0};
      vt[7]  = '{15, 4'hD, 4'h0, 1'b0};
      vt[8]  = '{18, 4'hB, 4'h0, 1'b0};
      vt[9]  = '{26, 4'h7, 4'h0, 1'b0};
      vt[10] = '{32, 4'hF, 4'h0, 1'b0};
      vt[11] = '{34, 4'hE, 4'h0, 1'b0};

      nRST = 1'b0; LOAD = 1'b0; VALUE = '0; DOTS = '0; LZS = 1'b0;
      model_reset();
      #12;
      chk("rst_nan", 32'(nAN), 32'hF);
      chk("rst_din", 32'(DIN), 0);
      chk("rst_dot", 32'(DOT), 0);
      chk("rst_frame", 32'(FRAME), 0);
      @(negedge CLK);
      nRST = 1'b1;
      cyc  = 0;

      // Basic scan timing
      for (int i = 0; i < 12; i++) begin
         run_to(vt[i].cyc);
         chk("scan_nan", 32'(nAN), 32'(vt[i].nan));
         chk("scan_din", 32'(DIN), 32'(vt[i].din));
         chk("scan_dot", 32'(DOT), 32'(vt[i].dot));
      end

      // Mid-frame load shows only from the next digit-0 boundary
      load(16'h1A3F, 4'b0100);
      VALUE = '0; DOTS = '0;
      run_to(58);
      chk("hold_din", 32'(DIN), 0);
      run_to(63);
      chk("hold_frame", 32'(FRAME), 0);
      run_to(64);
      chk("swap_frame", 32'(FRAME), 1);
      run_to(65);
      chk("swap_frame_end", 32'(FRAME), 0);
      ed = '{4'hF, 4'h3, 4'hA, 4'h1};
      eo = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int d = 0; d < 4; d++) begin
         run_to(64 + d*PS + 2);
         chk("seq_din", 32'(DIN), 32'(ed[d]));
         chk("seq_dot", 32'(DOT), 32'(eo[d]));
      end

      // Two loads in one frame: last wins, single FRAME
      run_to(100);
      load(16'h1111, 4'b0000);
      run_to(110);
      load(16'h2222, 4'b0000);
      nfr = 0;
      while (cyc < 130) begin
         tick();
         if (FRAME) nfr++;
      end
      chk("one_frame", 32'(nfr), 1);
      chk("last_wins", 32'(DIN), 32'h2);

      // Load exactly on the boundary cycle bypasses pend
      run_to(159);
      load(16'h3456, 4'b0000);
      chk("bypass_frame", 32'(FRAME), 1);
      chk("bypass_din", 32'(DIN), 32'h6);
      run_to(170);
      chk("bypass_d1", 32'(DIN), 32'h5);

      // Leading-zero suppression
      LZS = 1'b1;
      load(16'h0050, 4'b0000);
      run_to(194); chk("lzs_d0", 32'(nAN), 32'hE); chk("lzs_d0_din", 32'(DIN), 0);
      run_to(202); chk("lzs_d1", 32'(nAN), 32'hD); chk("lzs_d1_din", 32'(DIN), 5);
      run_to(210); chk("lzs_d2", 32'(nAN), 32'hF);
      run_to(218); chk("lzs_d3", 32'(nAN), 32'hF);
      run_to(220);
      load(16'h0000, 4'b0000);
      run_to(226); chk("lzs0_d0", 32'(nAN), 32'hE); chk("lzs0_din", 32'(DIN), 0);
      run_to(234); chk("lzs0_d1", 32'(nAN), 32'hF);
      run_to(250);
      load(16'h0000, 4'b1000);
      run_to(266); chk("lzsdot_d1", 32'(nAN), 32'hD);
      run_to(274); chk("lzsdot_d2", 32'(nAN), 32'hB);
      run_to(282); chk("lzsdot_d3", 32'(nAN), 32'h7); chk("lzsdot_dot", 32'(DOT), 1);

      // Asynchronous reset during digit 2 ON
      run_to(285);
      LZS = 1'b0;
      load(16'h9876, 4'b0000);
      run_to(307);
      chk("pre_rst_nan", 32'(nAN), 32'hB);
      chk("pre_rst_din", 32'(DIN), 32'h8);
      #2;
      nRST = 1'b0;
      #1;
      chk("async_nan", 32'(nAN), 32'hF);
      chk("async_din", 32'(DIN), 0);
      chk("async_frame", 32'(FRAME), 0);
      model_reset();
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      cyc  = 0;
      run_to(2);
      chk("restart_nan", 32'(nAN), 32'hE);
      chk("restart_din", 32'(DIN), 0);
      run_to(10);
      chk("restart_d1", 32'(nAN), 32'hD);

      // Random loads across many frames
      for (int f = 0; f < 1000; f++) begin
         if ($urandom_range(3) == 0) LZS = 1'($urandom_range(1));
         for (int c = 0; c < FR; c++) begin
            if ($urandom_range(19) == 0) begin
               VALUE = 16'($urandom) >> $urandom_range(16);
               DOTS  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
               LOAD  = 1'b1;
            end
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display.
- Sits directly upstream of the team's hex-to-segment decoder. It presents one nibble plus its dot on DIN/DOT, and drives the active-low digit enables nAN.
- The display value is double-buffered and swapped only at frame boundaries, so the display never tears.
- Inter-digit blanking suppresses ghosting. Optional leading-zero suppression is provided.

Parameters:
- NDIG, 8, number of digits; 2..8.
- PRESCALE, 50000, CLK cycles per digit slot; must be >= 2.
- BLANK_CYC, 1000, cycles at the start of each slot with all digits off; must satisfy 1 <= BLANK_CYC < PRESCALE.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- LOAD  in  1  single-cycle strobe; capture VALUE/DOTS.
- VALUE  in  4*NDIG  display value; nibble i goes to digit i, digit 0 = least significant.
- DOTS  in  NDIG  per-digit decimal-point request, 1 = lit.
- LZS  in  1  leading-zero suppression enable; sampled continuously.
- DIN  out  4  nibble for current digit, to the decoder.
- DOT  out  1  dot for current digit, to the decoder.
- nAN  out  NDIG  digit enables; active-low, at most one bit low.
- FRAME  out  1  one-cycle pulse when the active buffer is updated (start of digit 0).

Behaviour:
- Interface: one clock, CLK. Reset nRST is asynchronous and active-low. All state and outputs are registered on CLK.
- Reset values:
  - slot counter 0, digit index 0, phase BLANK;
  - pend_val / act_val = 0, pend_dots / act_dots = 0, dirty = 0;
  - DIN = 0, DOT = 0, nAN = all ones, FRAME = 0.
- Reset mid-scan immediately forces nAN all ones. Scanning restarts at digit 0 in BLANK after nRST deasserts.
- Slot counter counts 0..PRESCALE-1, then wraps to 0. Wrap is the slot boundary.
- Phase FSM:
  - BLANK: nAN = all ones. When counter = BLANK_CYC-1, go to ON.
  - ON: nAN bit [idx] = 0 (unless suppressed), others 1. At the slot boundary, go to BLANK and set idx = (idx+1) mod NDIG.
- DIN/DOT are updated on the cycle entering BLANK for the new idx, from act_val nibble idx / act_dots[idx]. They stay stable for the whole slot, so the decoder output settles before the anode turns on.
- Buffering:
  - LOAD captures VALUE/DOTS into pend_val / pend_dots and sets dirty.
  - At each boundary into idx 0: if dirty, copy pend to act, clear dirty, and pulse FRAME for one cycle. Otherwise FRAME stays 0.
  - LOAD in the same cycle as that boundary bypasses pend: VALUE/DOTS go straight to act, FRAME pulses, dirty stays 0.
  - LOAD on any other cycle only overwrites pend. The last LOAD before the boundary wins.
- Leading-zero suppression: with LZS = 1, digit i > 0 is suppressed when:
  - act_val nibbles i..NDIG-1 are all 0, and
  - act_dots bits i..NDIG-1 are all 0.
  A suppressed digit keeps nAN all ones during its ON phase, but its slot timing is unchanged. Digit 0 is never suppressed.
- Frame period = NDIG * PRESCALE cycles. Duty per digit = (PRESCALE - BLANK_CYC) / (NDIG * PRESCALE).
- Counter width = clog2(PRESCALE); idx width = clog2(NDIG) (minimum 1).

Decomposition:
- Shared package holds:
  - digit-enable all-off constant;
  - phase enum {PH_BLANK, PH_ON};
  - clog2-style width function.
- One natural sub-module, seg7_prescaler: a free-running modulo-PRESCALE counter with terminal-count and blank-end strobes.
- Phase FSM, buffers and suppression logic stay in seg7_scan.

Test Plan:
All scenarios use NDIG = 4, PRESCALE = 8, BLANK_CYC = 2.
1. Reset and scan. Hold nRST low, then release.
   -> nAN = 4'b1111, DIN = 0, DOT = 0.
   -> cycles 0-1: nAN = 1111; cycles 2-7: 1110; cycles 8-9: 1111; cycles 10-15: 1101.
   -> after 32 cycles, back to 1110.
2. LOAD VALUE = 16'h1A3F, DOTS = 4'b0100 mid-frame.
   -> no change until the next digit-0 boundary, where FRAME pulses for 1 cycle.
   -> DIN sequence F, 3, A, 1; DOT = 1 only on digit 2.
3. Two LOADs (16'h1111 then 16'h2222) within one frame.
   -> only 16'h2222 is displayed; exactly one FRAME pulse.
   -> LOAD exactly on the boundary cycle shows the new value in that same frame.
4. LZS = 1, VALUE = 16'h0050, DOTS = 0.
   -> digits 3 and 2 keep nAN all ones during ON; digits 1 and 0 light with DIN = 5, 0.
   -> VALUE = 16'h0000: only digit 0 lights, DIN = 0.
   -> DOTS = 4'b1000 with VALUE = 0: all digits light.
5. Assert nRST low during digit 2's ON phase.
   -> nAN = 1111 in the same cycle (asynchronous), act_val = 0.
   -> after release, scan restarts at digit 0 in BLANK.
6. Random LOADs over 1000 frames, checked by a scoreboard.
   -> never more than one nAN bit low; nAN all ones for the first BLANK_CYC cycles of each slot.
   -> DIN/DOT never change while any nAN bit is low.
